// File: rtl/truth_table_sequencer_if.sv
// rtl/truth_table_sequencer_if.sv - control/result bundle between the sequencer and its start/observer side
// Optional macro TT_CAPTURE_EN adds the f_table signal.
interface truth_table_sequencer_if #(
  parameter int N_INPUTS = 3
);
  logic                       start;
  logic [N_INPUTS-1:0]        vec;
  logic                       f_in;
  logic                       fs_in;
  logic                       busy;
  logic                       done;
  logic                       pass;
  logic [N_INPUTS:0]          mismatch_count;
  logic [N_INPUTS-1:0]        first_fail;
  logic                       first_fail_valid;
`ifdef TT_CAPTURE_EN
  logic [(1<<N_INPUTS)-1:0]   f_table;

  modport master (
    input  start, f_in, fs_in,
    output vec, busy, done, pass, mismatch_count, first_fail, first_fail_valid, f_table
  );

  modport slave (
    output start, f_in, fs_in,
    input  vec, busy, done, pass, mismatch_count, first_fail, first_fail_valid, f_table
  );
`else
  modport master (
    input  start, f_in, fs_in,
    output vec, busy, done, pass, mismatch_count, first_fail, first_fail_valid
  );

  modport slave (
    output start, f_in, fs_in,
    input  vec, busy, done, pass, mismatch_count, first_fail, first_fail_valid
  );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - exhaustive F vs Fs sweep controller for a small combinational unit
// Optional macro TT_CAPTURE_EN: records F for every vector into f_table.
module truth_table_sequencer #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  truth_table_sequencer_if.master       bus
);

  localparam int          CW         = N_INPUTS + 1;
  localparam int unsigned LAST       = (1 << N_INPUTS) - 1;
  // Vector counter carries one extra bit so the terminal compare is full width.
  localparam logic [CW-1:0] LAST_VEC    = CW'(LAST);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_vec;
  logic [3:0]            r_settle;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [CW-1:0]         r_mismatch_count;
  logic [N_INPUTS-1:0]   r_first_fail;
  logic                  r_first_fail_valid;
`ifdef TT_CAPTURE_EN
  logic [LAST:0]         r_f_table;
`endif

  // f_in/fs_in only matter in SAMPLE; elsewhere these wires are never consumed.
  logic                  w_mismatch;
  logic                  w_last;
  logic [CW-1:0]         w_count_next;

  assign w_mismatch   = bus.f_in ^ bus.fs_in;
  assign w_last       = (r_vec == LAST_VEC);
  assign w_count_next = r_mismatch_count + CW'(w_mismatch);

  // Sweep FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state            <= S_IDLE;
      r_vec              <= '0;
      r_settle           <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_mismatch_count   <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
`ifdef TT_CAPTURE_EN
      r_f_table          <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state            <= S_STEP;
            r_vec              <= '0;
            r_settle           <= '0;
            r_busy             <= 1'b1;
            r_pass             <= 1'b0;
            r_mismatch_count   <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
`ifdef TT_CAPTURE_EN
            r_f_table          <= '0;
`endif
          end
        end

        S_STEP: begin
          r_settle <= r_settle + 4'd1;
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          r_mismatch_count <= w_count_next;
          if (w_mismatch && !r_first_fail_valid) begin
            r_first_fail       <= r_vec[N_INPUTS-1:0];
            r_first_fail_valid <= 1'b1;
          end
`ifdef TT_CAPTURE_EN
          r_f_table[r_vec[N_INPUTS-1:0]] <= bus.f_in;
`endif
          if (w_last) begin
            // vec stays on the last vector; pass reflects this final sample too.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_count_next == '0);
          end else begin
            r_state  <= S_STEP;
            r_vec    <= r_vec + CW'(1);
            r_settle <= '0;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec              = r_vec[N_INPUTS-1:0];
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.mismatch_count   = r_mismatch_count;
  assign bus.first_fail       = r_first_fail;
  assign bus.first_fail_valid = r_first_fail_valid;
`ifdef TT_CAPTURE_EN
  assign bus.f_table          = r_f_table;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed self-checking bench for truth_table_sequencer
// Optional macro TT_CAPTURE_EN enables the f_table checks.
module tb_truth_table_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   mode;

  truth_table_sequencer_if #(.N_INPUTS(3)) intf ();

  truth_table_sequencer #(
    .N_INPUTS      (3),
    .SETTLE_CYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit under test model: F = A&B | C with A = vec[2]; Fs per mode.
  logic w_f;
  assign w_f        = (intf.vec[2] & intf.vec[1]) | intf.vec[0];
  assign intf.f_in  = w_f;
  assign intf.fs_in = (mode == 2) ? ~w_f :
                      ((mode == 1) && (intf.vec == 3'd5)) ? ~w_f : w_f;

  // Pulse start for one acceptance edge and wait for done; k_done counts edges after acceptance.
  task automatic run_once(output int k_done);
    int k;
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    intf.start = 1'b0;
    k = 0;
    while (!intf.done && k < 200) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    k_done = k;
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    intf.start = 1'b0;
    mode       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({intf.vec, intf.busy, intf.done, intf.pass, intf.mismatch_count,
         intf.first_fail, intf.first_fail_valid} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vec=%0d busy=%0d done=%0d pass=%0d cnt=%0d ff=%0d ffv=%0d expected all 0",
               intf.vec, intf.busy, intf.done, intf.pass, intf.mismatch_count,
               intf.first_fail, intf.first_fail_valid);
    end
`ifdef TT_CAPTURE_EN
    checks++;
    if (intf.f_table !== 8'd0) begin
      errors++;
      $display("FAIL reset_f_table: got %b expected 00000000", intf.f_table);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (intf.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %0d expected 0", intf.busy);
    end
  endtask

  task automatic test_pass_sweep;
    int k;
    int bad;
    mode = 0;
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    intf.start = 1'b0;
    k   = 0;
    bad = 0;
    while (!intf.done && k < 200) begin
      if (bad < 4) begin
        checks++;
        if (intf.vec !== 3'(k / 3) || intf.busy !== 1'b1) begin
          errors++;
          bad++;
          $display("FAIL sweep_vec k=%0d: got vec=%0d busy=%0d expected vec=%0d busy=1",
                   k, intf.vec, intf.busy, k / 3);
        end
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 24) begin
      errors++;
      $display("FAIL pass_done_latency: got %0d expected 24", k);
    end
    checks++;
    if (intf.pass !== 1'b1 || intf.mismatch_count !== 4'd0 || intf.first_fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_results: got pass=%0d cnt=%0d ffv=%0d expected pass=1 cnt=0 ffv=0",
               intf.pass, intf.mismatch_count, intf.first_fail_valid);
    end
    checks++;
    if (intf.vec !== 3'd7 || intf.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_state: got vec=%0d busy=%0d expected vec=7 busy=0", intf.vec, intf.busy);
    end
`ifdef TT_CAPTURE_EN
    checks++;
    if (intf.f_table !== 8'b1110_1010) begin
      errors++;
      $display("FAIL f_table: got %b expected 11101010", intf.f_table);
    end
`endif
    @(negedge clk);
    checks++;
    if (intf.done !== 1'b0 || intf.pass !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%0d pass=%0d expected done=0 pass=1", intf.done, intf.pass);
    end
  endtask

  task automatic test_single_fail;
    int k;
    mode = 1;
    run_once(k);
    checks++;
    if (k !== 24) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 24", k);
    end
    checks++;
    if (intf.mismatch_count !== 4'd1 || intf.first_fail !== 3'd5 ||
        intf.first_fail_valid !== 1'b1 || intf.pass !== 1'b0) begin
      errors++;
      $display("FAIL single_results: got cnt=%0d ff=%0d ffv=%0d pass=%0d expected cnt=1 ff=5 ffv=1 pass=0",
               intf.mismatch_count, intf.first_fail, intf.first_fail_valid, intf.pass);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (intf.mismatch_count !== 4'd1 || intf.first_fail !== 3'd5) begin
      errors++;
      $display("FAIL single_hold: got cnt=%0d ff=%0d expected cnt=1 ff=5",
               intf.mismatch_count, intf.first_fail);
    end
  endtask

  task automatic test_all_fail;
    int k;
    mode = 2;
    run_once(k);
    checks++;
    if (intf.mismatch_count !== 4'b1000 || intf.first_fail !== 3'd0 ||
        intf.first_fail_valid !== 1'b1 || intf.pass !== 1'b0) begin
      errors++;
      $display("FAIL all_fail_results: got cnt=%0d ff=%0d ffv=%0d pass=%0d expected cnt=8 ff=0 ffv=1 pass=0",
               intf.mismatch_count, intf.first_fail, intf.first_fail_valid, intf.pass);
    end
`ifdef TT_CAPTURE_EN
    checks++;
    if (intf.f_table !== 8'b1110_1010) begin
      errors++;
      $display("FAIL all_fail_f_table: got %b expected 11101010", intf.f_table);
    end
`endif
  endtask

  task automatic test_mid_reset;
    int k;
    mode = 2;
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    intf.start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (intf.vec !== 3'd3 || intf.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset: got vec=%0d busy=%0d expected vec=3 busy=1", intf.vec, intf.busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({intf.vec, intf.busy, intf.done, intf.pass, intf.mismatch_count,
         intf.first_fail, intf.first_fail_valid} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got vec=%0d busy=%0d done=%0d pass=%0d cnt=%0d ff=%0d ffv=%0d expected all 0",
               intf.vec, intf.busy, intf.done, intf.pass, intf.mismatch_count,
               intf.first_fail, intf.first_fail_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (intf.busy !== 1'b0 || intf.vec !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_idle: got busy=%0d vec=%0d expected busy=0 vec=0", intf.busy, intf.vec);
    end
    mode = 0;
    run_once(k);
    checks++;
    if (k !== 24 || intf.pass !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_rerun: got latency=%0d pass=%0d expected latency=24 pass=1", k, intf.pass);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    int n_done;
    int d[3];
    int width_bad;
    mode       = 0;
    n_done     = 0;
    width_bad  = 0;
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    while (n_done < 3 && k < 400) begin
      if (intf.done) begin
        d[n_done] = k;
        n_done++;
      end
      if (n_done >= 3) begin
        intf.start = 1'b0;
      end else if (n_done == 2 && intf.busy) begin
        // Toggle start during the third sweep; it must not restart anything.
        intf.start = k[0];
      end else begin
        intf.start = 1'b1;
      end
      if (n_done < 3) begin
        @(posedge clk);
        @(negedge clk);
        k++;
        if (intf.done && n_done > 0 && d[n_done-1] == k - 1) width_bad++;
      end
    end
    checks++;
    if (n_done !== 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 3", n_done);
    end else begin
      checks++;
      if (d[0] !== 24 || d[1] !== 50 || d[2] !== 76) begin
        errors++;
        $display("FAIL b2b_done_times: got %0d,%0d,%0d expected 24,50,76", d[0], d[1], d[2]);
      end
    end
    checks++;
    if (width_bad !== 0) begin
      errors++;
      $display("FAIL b2b_done_width: got %0d wide pulses expected 0", width_bad);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (intf.busy !== 1'b0 || intf.done !== 1'b0 || intf.pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final_idle: got busy=%0d done=%0d pass=%0d expected busy=0 done=0 pass=1",
               intf.busy, intf.done, intf.pass);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mode       = 0;
    rst_n      = 1'b0;
    intf.start = 1'b0;
    test_reset();
    test_pass_sweep();
    test_single_fail();
    test_all_fail();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Controller that exhaustively drives a small combinational unit under test (original function F and simplified form Fs over N inputs). It steps through every input vector in ascending binary order, waits a fixed settle time, and compares F against Fs at each vector. It reports pass/fail, the mismatch count and the first failing vector. It sits between a bench or top-level start control and the combinational block being checked.

Parameters:
N_INPUTS, 3, number of inputs to the unit under test; vectors 0 .. 2^N_INPUTS-1; legal range 1..8.
SETTLE_CYCLES, 2, cycles each vector is held before the sample cycle; legal range 1..15.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  level; sampled only in IDLE.
vec  out  N_INPUTS  drive to the unit under test, MSB = A.
f_in  in  1  F output of the unit under test.
fs_in  in  1  Fs output of the unit under test.
busy  out  1  high from the first STEP cycle through the last SAMPLE cycle.
done  out  1  one-cycle pulse in the DONE state.
pass  out  1  valid after done; 1 when mismatch_count == 0.
mismatch_count  out  N_INPUTS+1  number of vectors where f_in != fs_in.
first_fail  out  N_INPUTS  lowest failing vector.
first_fail_valid  out  1  first_fail holds a captured value.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-run:
  - State goes to IDLE.
  - vec, busy, done, pass, mismatch_count, first_fail and first_fail_valid all go to 0.
  - Settle counter is cleared.
- States: IDLE, STEP, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge moves to STEP.
  - On that edge: vec=0, settle counter=0, mismatch_count, first_fail, first_fail_valid and pass cleared.
  - start=0 holds IDLE; results of the previous run are held.
- STEP:
  - busy=1; vec stable.
  - Settle counter increments each cycle.
  - After SETTLE_CYCLES cycles in STEP, moves to SAMPLE.
- SAMPLE (one cycle):
  - At the edge leaving SAMPLE, f_in and fs_in are compared.
  - On mismatch: mismatch_count increments.
  - On mismatch with first_fail_valid=0: first_fail=vec and first_fail_valid=1.
  - If vec == 2^N_INPUTS-1: moves to DONE.
  - Otherwise: vec increments, settle counter clears, moves to STEP.
  - vec never wraps during a run.
- DONE (one cycle):
  - done=1, busy=0.
  - pass = (mismatch_count == 0), registered on entry to DONE.
  - vec holds the last vector.
  - Unconditionally moves to IDLE; start is ignored in DONE.
  - If start is still high in the following IDLE cycle, a new run begins.
- Latency: vector i enters STEP (SETTLE_CYCLES+1)*i cycles after start is accepted.
  - done rises 2^N_INPUTS*(SETTLE_CYCLES+1) cycles after acceptance.
  - Defaults: 24 cycles.
- Width rules:
  - mismatch_count is N_INPUTS+1 bits, so the maximum value 2^N_INPUTS is representable with no saturation needed.
  - The vector counter is N_INPUTS+1 bits internally; the terminal compare uses the full width.
- start while busy is ignored; no abort except rst_n.
- f_in and fs_in are ignored outside SAMPLE; X on them outside SAMPLE must not affect any output.

Optional Feature:
TT_CAPTURE_EN:
- Defined:
  - Adds output f_table [2^N_INPUTS-1:0].
  - Bit i is written with f_in at vector i's SAMPLE edge.
  - Cleared on reset and on start acceptance.
  - Valid when done pulses, held until the next start.
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. Defaults, fs_in tied equal to f_in (F=A&B|C), start pulsed 1 cycle:
   - vec sequences 0..7, each held 3 cycles.
   - done at cycle 24.
   - pass=1, mismatch_count=0, first_fail_valid=0.
2. fs_in = f_in except inverted when vec==5:
   - mismatch_count=1, first_fail=5, first_fail_valid=1, pass=0.
3. fs_in = ~f_in always:
   - mismatch_count=8 (4'b1000), first_fail=0, pass=0.
   - Confirms no overflow.
4. rst_n=0 for one edge while vec==3 in STEP:
   - Next cycle all outputs are 0 and state is IDLE.
   - A new start sweeps from vec=0, and done arrives exactly 24 cycles later.
5. start held high continuously:
   - done pulses every 26 cycles (24 + DONE + IDLE).
   - start pulses during busy do not restart the sweep or shorten it.
6. TT_CAPTURE_EN defined, F=A&B|C:
   - f_table=8'b1110_1010 at done (bit i = F(i)).
   - Rebuild without the macro: port absent, and scenarios 1–5 give identical results.
